// File: rtl/loop_divider_param.sv
// loop_divider_param
// ------------------
// Programmable, glitch-free integer clock divider for the PLL feedback path.
// Produces a 50%-duty divided clock for both even and odd divisors (odd
// divisors use a negedge stretch flop), its complement, and a one-cycle sync
// pulse at the start of every output period. A new divisor is taken through
// a request/acknowledge handshake and only becomes active at a period
// boundary, so no output phase is ever truncated.
//
// Build option: define PHASE_SWALLOW_EN to add the 'swallow' input, which
// stretches the current period by one clk cycle (one-cycle phase retard).
//
// Ports:
//   clk        VCO clock (posedge logic, plus one negedge stretch flop)
//   rstn_s     asynchronous, active-low reset
//   en         run enable (level)
//   div_n      requested divisor, sampled only when a request is accepted
//   div_req    divisor update request
//   div_ack    one-cycle pulse: the requested divisor is now in effect
//   div_err    sticky: a request asked for N < 2 (N = 2 was used instead)
//   clko       divided clock
//   clkob      inverse of clko
//   sync_p     one-cycle pulse in the cycle where the period counter is 0
//   busy       high whenever the FSM is not IDLE
//   state_dbg  current FSM state (0 IDLE, 1 RUN, 2 PEND, 3 STOP)
//   swallow    (PHASE_SWALLOW_EN only) lengthen the current period by 1 clk
//
// Handshake: the requester raises div_req with div_n stable and holds both
// until it sees div_ack high; it drops div_req before the next posedge. A
// div_req still high in the div_ack cycle belongs to the finished request
// and is never accepted again.
module loop_divider_param #(
  parameter int DW      = 8,
  parameter int DIV_RST = 4
) (
  input  logic          clk,
  input  logic          rstn_s,
  input  logic          en,
  input  logic [DW-1:0] div_n,
  input  logic          div_req,
`ifdef PHASE_SWALLOW_EN
  input  logic          swallow,
`endif
  output logic          div_ack,
  output logic          div_err,
  output logic          clko,
  output logic          clkob,
  output logic          sync_p,
  output logic          busy,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam logic [DW-1:0] ONE  = DW'(1);
  localparam logic [DW-1:0] TWO  = DW'(2);
  localparam logic [DW-1:0] NRST = DW'(DIV_RST);

  state_t        state, state_nx;
  logic [DW-1:0] nact, nact_nx;
  logic [DW-1:0] npend, npend_nx;
  logic [DW-1:0] cnt, cnt_nx, cnt_step;
  logic [DW-1:0] half, div_fix;
  logic          clko_r, clko_r_nx, clko_ne;
  logic          sync_nx, ack_nx, err_nx;
  logic          req_ok, bad_n, last, hold, wrap;

  assign half    = nact >> 1;
  assign bad_n   = (div_n < TWO);
  assign div_fix = bad_n ? TWO : div_n;
  assign req_ok  = div_req & ~div_ack;
  assign last    = (cnt == nact - ONE);

`ifdef PHASE_SWALLOW_EN
  // A swallow request parks the counter at nact-1 for one extra cycle,
  // which lengthens the low phase only.
  logic sw_pend, sw_nx;

  assign hold = last & sw_pend;

  always_comb begin
    sw_nx = sw_pend;
    if (state == IDLE || state_nx == IDLE) begin
      sw_nx = 1'b0;
    end else if (hold) begin
      sw_nx = 1'b0;
    end else if (swallow && (state == RUN || state == PEND)) begin
      sw_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn_s) begin
    if (!rstn_s) sw_pend <= 1'b0;
    else         sw_pend <= sw_nx;
  end
`else
  assign hold = 1'b0;
`endif

  assign wrap = last & ~hold;

  always_comb begin
    if (hold)      cnt_step = cnt;
    else if (wrap) cnt_step = '0;
    else           cnt_step = cnt + ONE;
  end

  // Next-state / output logic. While counting, clko_r tracks (cnt < half)
  // one register stage ahead so it is glitch-free.
  always_comb begin
    state_nx  = state;
    nact_nx   = nact;
    npend_nx  = npend;
    cnt_nx    = cnt_step;
    clko_r_nx = (cnt_step < half);
    sync_nx   = (cnt_step == '0);
    ack_nx    = 1'b0;
    err_nx    = div_err;
    case (state)
      IDLE: begin
        cnt_nx    = '0;
        clko_r_nx = 1'b0;
        sync_nx   = 1'b0;
        if (req_ok) begin
          nact_nx = div_fix;
          ack_nx  = 1'b1;
          err_nx  = div_err | bad_n;
        end
        if (en) begin
          // half >= 1 always, so the first cycle of a period is high.
          state_nx  = RUN;
          clko_r_nx = 1'b1;
          sync_nx   = 1'b1;
        end
      end
      RUN: begin
        if (req_ok && wrap) begin
          // Request lands exactly on the boundary: apply it right away.
          nact_nx  = div_fix;
          ack_nx   = 1'b1;
          err_nx   = div_err | bad_n;
          state_nx = en ? RUN : STOP;
        end else if (req_ok) begin
          npend_nx = div_fix;
          err_nx   = div_err | bad_n;
          state_nx = PEND;
        end else if (!en) begin
          if (wrap) begin
            state_nx  = IDLE;
            cnt_nx    = '0;
            clko_r_nx = 1'b0;
            sync_nx   = 1'b0;
          end else begin
            state_nx = STOP;
          end
        end
      end
      PEND: begin
        if (wrap) begin
          nact_nx  = npend;
          ack_nx   = 1'b1;
          state_nx = en ? RUN : STOP;
        end
      end
      STOP: begin
        if (en) begin
          state_nx = RUN;
        end else if (wrap) begin
          state_nx  = IDLE;
          cnt_nx    = '0;
          clko_r_nx = 1'b0;
          sync_nx   = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn_s) begin
    if (!rstn_s) begin
      state   <= IDLE;
      nact    <= NRST;
      npend   <= NRST;
      cnt     <= '0;
      clko_r  <= 1'b0;
      sync_p  <= 1'b0;
      div_ack <= 1'b0;
      div_err <= 1'b0;
    end else begin
      state   <= state_nx;
      nact    <= nact_nx;
      npend   <= npend_nx;
      cnt     <= cnt_nx;
      clko_r  <= clko_r_nx;
      sync_p  <= sync_nx;
      div_ack <= ack_nx;
      div_err <= err_nx;
    end
  end

  // Odd divisors: holding the high phase half a clk longer gives N/2 high.
  always_ff @(negedge clk or negedge rstn_s) begin
    if (!rstn_s) clko_ne <= 1'b0;
    else         clko_ne <= clko_r & nact[0];
  end

  assign clko      = clko_r | clko_ne;
  assign clkob     = ~clko;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_loop_divider_param.sv
// tb_loop_divider_param
// ---------------------
// Directed bench for loop_divider_param (DW=8, DIV_RST=4). The expected
// output stream is built from first principles: a period of N clk cycles is
// 2N half-cycle samples, of which the first N are high; sync_p marks the
// first cycle; div_ack marks the first cycle after a divisor change. Samples
// are taken 1 time unit after each posedge and each negedge. Define
// PHASE_SWALLOW_EN to include the swallow scenario.
module tb_loop_divider_param;

  localparam int DW = 8;

  logic          clk;
  logic          rstn_s;
  logic          en;
  logic [DW-1:0] div_n;
  logic          div_req;
  logic          div_ack;
  logic          div_err;
  logic          clko;
  logic          clkob;
  logic          sync_p;
  logic          busy;
  logic [1:0]    state_dbg;
`ifdef PHASE_SWALLOW_EN
  logic          swallow;
`endif

  int tests = 0;
  int fails = 0;
  int phase = 0;

  // entry = {busy, clko, sync_p, div_ack}
  logic [3:0] exp_q[$];

  loop_divider_param #(.DW(DW), .DIV_RST(4)) dut (
    .clk       (clk),
    .rstn_s    (rstn_s),
    .en        (en),
    .div_n     (div_n),
    .div_req   (div_req),
`ifdef PHASE_SWALLOW_EN
    .swallow   (swallow),
`endif
    .div_ack   (div_ack),
    .div_err   (div_err),
    .clko      (clko),
    .clkob     (clkob),
    .sync_p    (sync_p),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // drivers / model
  task automatic push_period(input int n, input int len, input bit ack_first);
    for (int h = 0; h < 2 * len; h++)
      exp_q.push_back({1'b1, (h < n), (h < 2), (ack_first && h < 2)});
  endtask

  task automatic push_idle(input int cycles, input bit ack_first);
    for (int h = 0; h < 2 * cycles; h++)
      exp_q.push_back({1'b0, 1'b0, 1'b0, (ack_first && h < 2)});
  endtask

  // scoreboard: pop one expected entry per half-cycle sample
  task automatic drain_n(input int k, input string tag);
    logic [3:0] e;
    for (int i = 0; i < k; i++) begin
      if (phase == 0) @(posedge clk);
      else            @(negedge clk);
      #1;
      phase = 1 - phase;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL %s: observed empty queue expected entry", tag);
      end else begin
        e = exp_q.pop_front();
        chk(tag, {3'b000, busy, clko, clkob, sync_p, div_ack},
                 {3'b000, e[3], e[2], ~e[2], e[1], e[0]});
      end
    end
  endtask

  task automatic drain_all(input string tag);
    drain_n(exp_q.size(), tag);
  endtask

  initial begin
    rstn_s  = 1'b0;
    en      = 1'b0;
    div_n   = '0;
    div_req = 1'b0;
`ifdef PHASE_SWALLOW_EN
    swallow = 1'b0;
`endif

    // reset state
    #3;
    chk("reset_outputs", {2'b00, clko, clkob, div_ack, div_err, sync_p, busy}, 8'b0001_0000);
    chk("reset_state", {6'd0, state_dbg}, 8'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    rstn_s = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("idle_after_reset", {5'd0, busy, clko, sync_p}, 8'd0);

    // default divisor 4: 2 high / 2 low, sync every 4
    en = 1'b1;
    push_period(4, 4, 1'b0);
    push_period(4, 4, 1'b0);
    push_period(4, 4, 1'b0);
    drain_all("div4_run");

    // change to 7 mid-period: old period completes, ack at the boundary
    push_period(4, 4, 1'b0);
    drain_n(4, "div4_before_req");
    div_n   = 8'd7;
    div_req = 1'b1;
    push_period(7, 7, 1'b1);
    push_period(7, 7, 1'b0);
    drain_n(2, "div4_req_seen");
    chk("pend_state", {6'd0, state_dbg}, 8'd2);
    drain_n(4, "div7_ack");
    div_req = 1'b0;
    drain_all("div7_run");

    // request N=1: substituted by 2, sticky error
    push_period(7, 7, 1'b0);
    drain_n(2, "div7_before_bad");
    div_n   = 8'd1;
    div_req = 1'b1;
    push_period(2, 2, 1'b1);
    push_period(2, 2, 1'b0);
    push_period(2, 2, 1'b0);
    push_period(2, 2, 1'b0);
    drain_n(14, "div2_ack");
    div_req = 1'b0;
    drain_all("div2_run");
    chk("div_err_set", {7'd0, div_err}, 8'd1);

    // switch to 6, drop en at cnt=1: full period then idle
    push_period(2, 2, 1'b0);
    drain_n(2, "div2_before_req6");
    div_n   = 8'd6;
    div_req = 1'b1;
    push_period(6, 6, 1'b1);
    drain_n(4, "div6_ack");
    div_req = 1'b0;
    drain_n(2, "div6_cnt1");
    en = 1'b0;
    push_idle(3, 1'b0);
    drain_all("div6_stop");
    chk("div_err_sticky", {7'd0, div_err}, 8'd1);
    chk("idle_state", {6'd0, state_dbg}, 8'd0);

    // load 5 from IDLE, run, then reset while clko is high
    div_n   = 8'd5;
    div_req = 1'b1;
    push_idle(1, 1'b1);
    drain_all("idle_load5");
    div_req = 1'b0;
    en      = 1'b1;
    push_period(5, 5, 1'b0);
    drain_n(4, "div5_high");
    #2;
    rstn_s = 1'b0;
    #1;
    chk("reset_kills_clko", {4'd0, clko, clkob, busy, sync_p}, 8'b0000_0100);
    chk("reset_clears_err", {6'd0, div_err, div_ack}, 8'd0);
    exp_q.delete();
    @(posedge clk); #1;
    @(negedge clk); #1;
    rstn_s = 1'b1;
    push_period(4, 4, 1'b0);
    push_period(4, 4, 1'b0);
    drain_all("div4_after_reset");

`ifdef PHASE_SWALLOW_EN
    // two pulses in one period stretch it to 5 once, then back to 4
    push_period(4, 5, 1'b0);
    push_period(4, 4, 1'b0);
    drain_n(2, "sw_cnt0");
    swallow = 1'b1;
    drain_n(2, "sw_cnt1");
    swallow = 1'b0;
    drain_n(2, "sw_cnt2");
    swallow = 1'b1;
    drain_n(2, "sw_cnt3");
    swallow = 1'b0;
    drain_all("sw_tail");
`endif

    en = 1'b0;
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
